weight_board_accum: RTL and testbench

//  Receiving end of the scanners' weight-write interface (wr_en/wr_x/wr_y/wr_weight).

---
 rtl/weight_board_accum.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_weight_board_accum.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_board_accum.sv
// weight_board_accum: per-cell move-score accumulator for the 19x19 board.
// Takes scanner weight writes as 2-cycle saturating read-modify-writes with a
// same-cell bypass. On command it either clears the score RAM or sweeps it
// and reports the highest-scoring cell; ties go to the lowest index.
// Optional build macro: WBA_WR_ERR_EN adds a sticky wr_err output that flags
// dropped writes.
module weight_board_accum #(
    parameter int unsigned BRD     = 19,
    parameter int unsigned SCORE_W = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [4:0]         wr_x,
    input  logic [4:0]         wr_y,
    input  logic [3:0]         wr_weight,
    input  logic               clr_start,
    input  logic               find_start,
    output logic               busy,
    output logic               find_done,
    output logic               best_valid,
    output logic [4:0]         best_x,
    output logic [4:0]         best_y,
    output logic [SCORE_W-1:0] best_score
`ifdef WBA_WR_ERR_EN
    ,
    output logic               wr_err
`endif
);

    localparam int unsigned CELLS    = BRD * BRD;
    localparam int unsigned IDX_W    = $clog2(CELLS + 1);
    localparam int unsigned INC_W    = SCORE_W + 1;
    localparam int unsigned MAX_CODE = 8;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(CELLS - 1);
    localparam logic [IDX_W-1:0] END_IDX    = IDX_W'(CELLS);
    localparam logic [4:0]       LAST_COORD = 5'(BRD - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FIND,
        ST_DONE
    } state_t;

    // Score RAM: no reset, contents defined only after a clear.
    logic [SCORE_W-1:0] mem [CELLS];

    state_t state_q, state_d;

    // Sweep / clear address counter and the matching board coordinates.
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [4:0]         cx_q, cx_d;
    logic [4:0]         cy_q, cy_d;

    // Compare stage of the sweep (cell whose score sits in rd_data_q).
    logic               cmp_valid_q, cmp_valid_d;
    logic               cmp_last_q, cmp_last_d;
    logic [4:0]         cmp_x_q, cmp_x_d;
    logic [4:0]         cmp_y_q, cmp_y_d;

    // Second RMW stage of an accepted write.
    logic               s1_valid_q, s1_valid_d;
    logic [IDX_W-1:0]   s1_idx_q, s1_idx_d;
    logic [INC_W-1:0]   s1_inc_q, s1_inc_d;

    // Registered RAM read data, shared by the RMW path and the sweep.
    logic [SCORE_W-1:0] rd_data_q, rd_data_d;

    logic               busy_q, busy_d;
    logic               find_done_q, find_done_d;
    logic               best_valid_q, best_valid_d;
    logic [4:0]         best_x_q, best_x_d;
    logic [4:0]         best_y_q, best_y_d;
    logic [SCORE_W-1:0] best_score_q, best_score_d;

    // Decode and datapath nets.
    logic               wr_in_range;
    logic               start_ok;
    logic               clr_acc;
    logic               find_acc;
    logic               wr_acc;
    logic [IDX_W-1:0]   wr_idx;
    logic [INC_W-1:0]   wr_inc;
    logic [IDX_W-1:0]   rd_addr;
    logic [SCORE_W-1:0] rd_mem;
    logic [INC_W-1:0]   s1_sum;
    logic [SCORE_W-1:0] s1_new;
    logic               bypass;
    logic               mem_we;
    logic [IDX_W-1:0]   mem_waddr;
    logic [SCORE_W-1:0] mem_wdata;

    // Command and write acceptance; a start beats a same-cycle write.
    always_comb begin
        wr_in_range = (32'(wr_x) < BRD) && (32'(wr_y) < BRD)
                      && (32'(wr_weight) <= MAX_CODE);
        start_ok    = (state_q == ST_IDLE) && !busy_q;
        clr_acc     = start_ok && clr_start;
        find_acc    = start_ok && find_start && !clr_start;
        wr_acc      = (state_q == ST_IDLE) && wr_en && wr_in_range
                      && !clr_acc && !find_acc;
        wr_idx      = IDX_W'(32'(wr_x) * BRD + 32'(wr_y));
        wr_inc      = INC_W'(1) << wr_weight;
    end

    // RAM read port and saturating add for the second RMW stage.
    always_comb begin
        rd_addr = (state_q == ST_FIND) ? cnt_q : wr_idx;
        rd_mem  = (32'(rd_addr) < CELLS) ? mem[rd_addr] : '0;
        s1_sum  = {1'b0, rd_data_q} + s1_inc_q;
        s1_new  = s1_sum[SCORE_W] ? {SCORE_W{1'b1}} : s1_sum[SCORE_W-1:0];
        // A write to the cell still in flight must see its updated value.
        bypass  = s1_valid_q && (s1_idx_q == wr_idx);
    end

    // Next-state, counters, RMW pipeline, sweep compare and output values.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        cmp_valid_d  = 1'b0;
        cmp_last_d   = 1'b0;
        cmp_x_d      = cmp_x_q;
        cmp_y_d      = cmp_y_q;
        s1_valid_d   = 1'b0;
        s1_idx_d     = s1_idx_q;
        s1_inc_d     = s1_inc_q;
        rd_data_d    = rd_data_q;
        find_done_d  = 1'b0;
        best_x_d     = best_x_q;
        best_y_d     = best_y_q;
        best_score_d = best_score_q;
        mem_we       = s1_valid_q;
        mem_waddr    = s1_idx_q;
        mem_wdata    = s1_new;

        case (state_q)
            ST_IDLE: begin
                if (clr_acc) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end else if (find_acc) begin
                    state_d      = ST_FIND;
                    cnt_d        = '0;
                    cx_d         = '0;
                    cy_d         = '0;
                    best_x_d     = '0;
                    best_y_d     = '0;
                    best_score_d = '0;
                end else if (wr_acc) begin
                    s1_valid_d = 1'b1;
                    s1_idx_d   = wr_idx;
                    s1_inc_d   = wr_inc;
                    rd_data_d  = bypass ? s1_new : rd_mem;
                end
            end
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = '0;
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            ST_FIND: begin
                // Issue one read per cycle until every cell has been fetched.
                if (cnt_q != END_IDX) begin
                    rd_data_d   = rd_mem;
                    cmp_valid_d = 1'b1;
                    cmp_last_d  = (cnt_q == LAST_IDX);
                    cmp_x_d     = cx_q;
                    cmp_y_d     = cy_q;
                    cnt_d       = cnt_q + IDX_W'(1);
                    if (cy_q == LAST_COORD) begin
                        cy_d = '0;
                        cx_d = cx_q + 5'd1;
                    end else begin
                        cy_d = cy_q + 5'd1;
                    end
                end
                // Strictly greater only, so ties keep the earlier cell.
                if (cmp_valid_q && (rd_data_q > best_score_q)) begin
                    best_x_d     = cmp_x_q;
                    best_y_d     = cmp_y_q;
                    best_score_d = rd_data_q;
                end
                if (cmp_valid_q && cmp_last_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                find_done_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d       = (state_d != ST_IDLE) || s1_valid_d;
        best_valid_d = (best_score_d != '0);
    end

    // State and pipeline registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
            cmp_valid_q  <= 1'b0;
            cmp_last_q   <= 1'b0;
            cmp_x_q      <= '0;
            cmp_y_q      <= '0;
            s1_valid_q   <= 1'b0;
            s1_idx_q     <= '0;
            s1_inc_q     <= '0;
            rd_data_q    <= '0;
            busy_q       <= 1'b0;
            find_done_q  <= 1'b0;
            best_valid_q <= 1'b0;
            best_x_q     <= '0;
            best_y_q     <= '0;
            best_score_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            cmp_valid_q  <= cmp_valid_d;
            cmp_last_q   <= cmp_last_d;
            cmp_x_q      <= cmp_x_d;
            cmp_y_q      <= cmp_y_d;
            s1_valid_q   <= s1_valid_d;
            s1_idx_q     <= s1_idx_d;
            s1_inc_q     <= s1_inc_d;
            rd_data_q    <= rd_data_d;
            busy_q       <= busy_d;
            find_done_q  <= find_done_d;
            best_valid_q <= best_valid_d;
            best_x_q     <= best_x_d;
            best_y_q     <= best_y_d;
            best_score_q <= best_score_d;
        end
    end

    // Score RAM write port.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

`ifdef WBA_WR_ERR_EN
    logic wr_err_q, wr_err_d;

    // Sticky drop flag; only an accepted clear rearms it.
    always_comb begin
        wr_err_d = (clr_acc ? 1'b0 : wr_err_q) | (wr_en && !wr_acc);
    end

    // Drop flag register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_err_d;
        end
    end

    assign wr_err = wr_err_q;
`endif

    assign busy       = busy_q;
    assign find_done  = find_done_q;
    assign best_valid = best_valid_q;
    assign best_x     = best_x_q;
    assign best_y     = best_y_q;
    assign best_score = best_score_q;

endmodule

// File: tb/tb_weight_board_accum.sv
// Bench for weight_board_accum: a cell-score array model with argmax decides
// every find result and its completion cycle; a negedge monitor compares the
// outputs each cycle, and directed scenarios pin literal results.
module tb_weight_board_accum;

    localparam int BRD   = 19;
    localparam int CELLS = BRD * BRD;
    localparam int SMAX  = 4095;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_x = '0;
    logic [4:0]  wr_y = '0;
    logic [3:0]  wr_weight = '0;
    logic        clr_start = 1'b0;
    logic        find_start = 1'b0;
    logic        busy;
    logic        find_done;
    logic        best_valid;
    logic [4:0]  best_x;
    logic [4:0]  best_y;
    logic [11:0] best_score;
`ifdef WBA_WR_ERR_EN
    logic        wr_err;
`endif

    weight_board_accum dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_x       (wr_x),
        .wr_y       (wr_y),
        .wr_weight  (wr_weight),
        .clr_start  (clr_start),
        .find_start (find_start),
        .busy       (busy),
        .find_done  (find_done),
        .best_valid (best_valid),
        .best_x     (best_x),
        .best_y     (best_y),
        .best_score (best_score)
`ifdef WBA_WR_ERR_EN
        ,
        .wr_err     (wr_err)
`endif
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: plain per-cell scores plus the expected find result.
    int model [CELLS];
    bit fsm_busy = 1'b0;
    bit find_pending = 1'b0;
    bit hold = 1'b0;
    bit chk_en = 1'b0;
    int due = 0;
    int ex = 0, ey = 0, es = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_best(output int bx, output int by, output int bs);
        int bi;
        bi = 0;
        bs = 0;
        for (int i = 0; i < CELLS; i++) begin
            if (model[i] > bs) begin
                bs = model[i];
                bi = i;
            end
        end
        bx = bi / BRD;
        by = bi % BRD;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int x, input int y, input int code);
        int idx;
        wr_en = 1'b1;
        wr_x = 5'(x);
        wr_y = 5'(y);
        wr_weight = 4'(code);
        if (!fsm_busy && x < BRD && y < BRD && code <= 8) begin
            idx = x * BRD + y;
            model[idx] = model[idx] + (1 << code);
            if (model[idx] > SMAX) model[idx] = SMAX;
        end
        step();
        wr_en = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 1000) begin
            step();
            n++;
        end
        if (busy) chk("idle_timeout", int'(busy), 0);
    endtask

    task automatic start_clear(input bit with_find, input bit wait_done);
        int n;
        wait_idle();
        clr_start = 1'b1;
        find_start = with_find;
        for (int i = 0; i < CELLS; i++) model[i] = 0;
        fsm_busy = 1'b1;
        step();
        clr_start = 1'b0;
        find_start = 1'b0;
        if (wait_done) begin
            n = 0;
            while (busy && n < 500) begin
                step();
                n++;
            end
            chk("clear_cycles", n, 361);
            fsm_busy = 1'b0;
        end
    endtask

    task automatic start_find();
        wait_idle();
        find_start = 1'b1;
        model_best(ex, ey, es);
        hold = 1'b0;
        due = cyc + 364;
        find_pending = 1'b1;
        fsm_busy = 1'b1;
        step();
        find_start = 1'b0;
    endtask

    task automatic wait_find();
        int n;
        n = 0;
        while (find_pending && n < 600) begin
            step();
            n++;
        end
        if (find_pending) begin
            chk("find_timeout", int'(find_pending), 0);
            find_pending = 1'b0;
        end
        fsm_busy = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        wr_en = 1'b0;
        clr_start = 1'b0;
        find_start = 1'b0;
        find_pending = 1'b0;
        fsm_busy = 1'b0;
        hold = 1'b1;
        ex = 0;
        ey = 0;
        es = 0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_find_done", int'(find_done), 0);
        chk("rst_best_valid", int'(best_valid), 0);
        chk("rst_best_x", int'(best_x), 0);
        chk("rst_best_y", int'(best_y), 0);
        chk("rst_best_score", int'(best_score), 0);
`ifdef WBA_WR_ERR_EN
        chk("rst_wr_err", int'(wr_err), 0);
`endif
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic chk_best(input string tag, input int x, input int y, input int s);
        chk({tag, "_x"}, int'(best_x), x);
        chk({tag, "_y"}, int'(best_y), y);
        chk({tag, "_score"}, int'(best_score), s);
        chk({tag, "_valid"}, int'(best_valid), (s != 0) ? 1 : 0);
    endtask

    // Per-cycle monitor: find completion timing/result and held outputs.
    always @(negedge clk) begin
        if (chk_en) begin
            if (find_pending) begin
                if (cyc == due) begin
                    chk("find_done", int'(find_done), 1);
                    chk("find_x", int'(best_x), ex);
                    chk("find_y", int'(best_y), ey);
                    chk("find_score", int'(best_score), es);
                    chk("find_valid", int'(best_valid), (es != 0) ? 1 : 0);
                    find_pending = 1'b0;
                    hold = 1'b1;
                end else begin
                    chk("find_done_early", int'(find_done), 0);
                end
            end else begin
                chk("find_done_idle", int'(find_done), 0);
                if (hold) begin
                    chk("hold_x", int'(best_x), ex);
                    chk("hold_y", int'(best_y), ey);
                    chk("hold_score", int'(best_score), es);
                    chk("hold_valid", int'(best_valid), (es != 0) ? 1 : 0);
                end
            end
        end
    end

    initial begin
        step();
        chk_en = 1'b1;
        apply_reset();

        // 1: three weights into one cell, back to back.
        start_clear(1'b0, 1'b1);
        wr(3, 4, 0);
        wr(3, 4, 2);
        wr(3, 4, 8);
        start_find();
        wait_find();
        chk_best("t1", 3, 4, 261);

        // 2: bypass on three consecutive same-cell writes.
        start_clear(1'b0, 1'b1);
        wr(7, 7, 3);
        wr(7, 7, 3);
        wr(7, 7, 3);
        start_find();
        wait_find();
        chk_best("t2", 7, 7, 24);

        // 3: tie goes to the lower index, then a strict win.
        start_clear(1'b0, 1'b1);
        wr(0, 5, 4);
        wr(2, 1, 4);
        start_find();
        wait_find();
        chk_best("t3a", 0, 5, 16);
        wr(2, 1, 0);
        start_find();
        wait_find();
        chk_best("t3b", 2, 1, 17);

        // 4: saturation at the score ceiling.
        start_clear(1'b0, 1'b1);
        for (int i = 0; i < 20; i++) wr(18, 18, 8);
        start_find();
        wait_find();
        chk_best("t4", 18, 18, 4095);

        // 5: empty board, write lost during find, invalid writes ignored.
        start_clear(1'b0, 1'b1);
        start_find();
        repeat (20) step();
        wr(1, 1, 8);
        wait_find();
        chk_best("t5a", 0, 0, 0);
        start_find();
        wait_find();
        chk_best("t5b", 0, 0, 0);
        wr(19, 1, 0);
        wr(1, 1, 9);
        wr(2, 31, 0);
        start_find();
        wait_find();
        chk_best("t5c", 0, 0, 0);

        // clr_start with find_start: clear wins, no find completes.
        wr(5, 5, 1);
        start_clear(1'b1, 1'b1);
        start_find();
        wait_find();
        chk_best("tcf", 0, 0, 0);

        // 6: reset in the middle of CLEAR and of FIND.
        start_clear(1'b0, 1'b0);
        repeat (50) step();
        apply_reset();
        start_clear(1'b0, 1'b1);
        wr(4, 4, 1);
`ifdef WBA_WR_ERR_EN
        start_find();
        repeat (10) step();
        wr(0, 0, 0);
        chk("t6_wr_err_set", int'(wr_err), 1);
        wait_find();
        chk("t6_wr_err_sticky", int'(wr_err), 1);
        start_clear(1'b0, 1'b1);
        chk("t6_wr_err_clr", int'(wr_err), 0);
        wr(4, 4, 1);
`endif
        start_find();
        repeat (100) step();
        apply_reset();
        repeat (5) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
